// File: rtl/ab_seq_driver.sv
// Stimulus generator for "status |=> (a ##GAP b)": pipelined or serialised with collision drops.
// Optional embedded self-check assertion enabled by defining AB_SEQ_SELFCHECK_EN.
module ab_seq_driver #(
    parameter int unsigned GAP           = 2,
    parameter bit          ALLOW_OVERLAP = 1'b1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             status_i,
    output logic             a_o,
    output logic             b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] issue_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    if ((GAP < 1) || (GAP > 15)) begin : gen_gap_range_err
        $error("ab_seq_driver: GAP must be in 1..15");
    end

    logic req;
    logic accept;

    assign req = en_i & status_i;

    if (ALLOW_OVERLAP) begin : gen_pipe
        logic             a_q;
        logic [GAP-1:0]   sh_q;
        logic [GAP-1:0]   sh_d;
        logic [CNT_W-1:0] issue_q;

        assign accept = req;

        always_comb begin
            sh_d    = '0;
            sh_d[0] = a_q;
            for (int i = 1; i < int'(GAP); i++) begin
                sh_d[i] = sh_q[i-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_q     <= 1'b0;
                sh_q    <= '0;
                issue_q <= '0;
            end else begin
                a_q  <= accept;
                sh_q <= sh_d;
                if (accept) begin
                    issue_q <= issue_q + CNT_W'(1);
                end
            end
        end

        assign a_o         = a_q;
        assign b_o         = sh_q[GAP-1];
        assign done_o      = sh_q[GAP-1];
        assign busy_o      = a_q | (|sh_q);
        assign issue_cnt_o = issue_q;
        assign drop_cnt_o  = '0;
    end else begin : gen_fsm
        typedef enum logic [1:0] {StIdle, StAPh, StGapPh, StBPh} state_e;

        localparam logic [3:0] GapLoad = (GAP > 1) ? 4'(GAP - 2) : 4'd0;

        state_e           state_q;
        logic             a_q;
        logic             b_q;
        logic             busy_q;
        logic [3:0]       gap_q;
        logic [CNT_W-1:0] issue_q;
        logic [CNT_W-1:0] drop_q;
        logic             drop;

        // Only IDLE and the final B phase can take a new request; earlier phases drop it.
        assign accept = req & ((state_q == StIdle) | (state_q == StBPh));
        assign drop   = req & ((state_q == StAPh) | (state_q == StGapPh));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= StIdle;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                busy_q  <= 1'b0;
                gap_q   <= '0;
                issue_q <= '0;
                drop_q  <= '0;
            end else begin
                a_q <= 1'b0;
                b_q <= 1'b0;
                if (accept) begin
                    issue_q <= issue_q + CNT_W'(1);
                end
                if (drop) begin
                    drop_q <= drop_q + CNT_W'(1);
                end
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            state_q <= StAPh;
                            a_q     <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    StAPh: begin
                        if (GAP > 1) begin
                            state_q <= StGapPh;
                            gap_q   <= GapLoad;
                        end else begin
                            state_q <= StBPh;
                            b_q     <= 1'b1;
                        end
                    end
                    StGapPh: begin
                        if (gap_q == 4'd0) begin
                            state_q <= StBPh;
                            b_q     <= 1'b1;
                        end else begin
                            gap_q <= gap_q - 4'd1;
                        end
                    end
                    StBPh: begin
                        if (accept) begin
                            state_q <= StAPh;
                            a_q     <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign a_o         = a_q;
        assign b_o         = b_q;
        assign done_o      = b_q;
        assign busy_o      = busy_q;
        assign issue_cnt_o = issue_q;
        assign drop_cnt_o  = drop_q;
    end

`ifdef AB_SEQ_SELFCHECK_EN
    int unsigned sc_fail_cnt = 0;

    property p_ab_seq;
        @(posedge clk_i) disable iff (!rst_ni)
            (en_i && status_i && accept) |=> (a_o ##GAP b_o);
    endproperty

    a_ab_seq: assert property (p_ab_seq)
        else begin
            sc_fail_cnt++;
            $error("ab_seq_driver: a/b sequence violated at %0t", $time);
        end

    final $display("ab_seq_driver selfcheck: %0d assertion failures", sc_fail_cnt);
`else
`endif

endmodule

// File: tb/tb_ab_seq_driver.sv
// Directed table-driven bench for ab_seq_driver: three builds (GAP2 pipelined, GAP2 serial, GAP1 serial).
module tb_ab_seq_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       status = 1'b0;
    logic       a_w    [3];
    logic       b_w    [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic [7:0] ic_w   [3];
    logic [7:0] dc_w   [3];

    int nvec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ab_seq_driver #(.GAP(2), .ALLOW_OVERLAP(1'b1), .CNT_W(8)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .status_i(status),
        .a_o(a_w[0]), .b_o(b_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .issue_cnt_o(ic_w[0]), .drop_cnt_o(dc_w[0])
    );
    ab_seq_driver #(.GAP(2), .ALLOW_OVERLAP(1'b0), .CNT_W(8)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .status_i(status),
        .a_o(a_w[1]), .b_o(b_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .issue_cnt_o(ic_w[1]), .drop_cnt_o(dc_w[1])
    );
    ab_seq_driver #(.GAP(1), .ALLOW_OVERLAP(1'b0), .CNT_W(8)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .status_i(status),
        .a_o(a_w[2]), .b_o(b_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]),
        .issue_cnt_o(ic_w[2]), .drop_cnt_o(dc_w[2])
    );

    // Bit k of a mask = value sampled at posedge k (edge 1 is the first edge after reset release).
    typedef struct {
        string           name;
        logic            en;
        logic [19:0]     st;
        logic [2:0][19:0] ea;
        logic [2:0][19:0] eb;
        logic [2:0][19:0] ey;
        logic [2:0][7:0]  ic;
        logic [2:0][7:0]  dc;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [19:0] r(input int lo, input int hi);
        logic [19:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [19:0] p(input int k);
        return r(k, k);
    endfunction

    function automatic vec_t mk(input string n, input logic e, input logic [19:0] s,
                                input logic [19:0] a0, b0, y0, a1, b1, y1, a2, b2, y2,
                                input logic [7:0] ic0, dc0, ic1, dc1, ic2, dc2);
        vec_t v;
        v.name = n; v.en = e; v.st = s;
        v.ea = {a2, a1, a0};
        v.eb = {b2, b1, b0};
        v.ey = {y2, y1, y0};
        v.ic = {ic2, ic1, ic0};
        v.dc = {dc2, dc1, dc0};
        return v;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, got, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [2:0] ea, eb, ey);
        for (int d = 0; d < 3; d++) begin
            chk(nm, d, {28'd0, a_w[d], b_w[d], done_w[d], busy_w[d]},
                {28'd0, ea[d], eb[d], eb[d], ey[d]});
        end
    endtask

    task automatic chk_cnts(input string nm, input logic [2:0][7:0] ic, input logic [2:0][7:0] dc);
        for (int d = 0; d < 3; d++) begin
            chk({nm, " issue_cnt"}, d, {24'd0, ic_w[d]}, {24'd0, ic[d]});
            chk({nm, " drop_cnt"}, d, {24'd0, dc_w[d]}, {24'd0, dc[d]});
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b0;
        status = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        en = v.en;
        chk_cnts({v.name, " reset"}, '0, '0);
        for (int k = 1; k <= 18; k++) begin
            chk_outs($sformatf("%s e%0d", v.name, k),
                     {v.ea[2][k], v.ea[1][k], v.ea[0][k]},
                     {v.eb[2][k], v.eb[1][k], v.eb[0][k]},
                     {v.ey[2][k], v.ey[1][k], v.ey[0][k]});
            status = v.st[k];
            @(posedge clk);
            @(negedge clk);
        end
        chk_cnts(v.name, v.ic, v.dc);
    endtask

    initial begin
        vecs[0] = mk("single", 1'b1, p(2),
                     p(3), p(5), r(3, 5),
                     p(3), p(5), r(3, 5),
                     p(3), p(4), r(3, 4),
                     8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0);
        vecs[1] = mk("hold", 1'b1, r(2, 9),
                     r(3, 10), r(5, 12), r(3, 12),
                     p(3) | p(6) | p(9), p(5) | p(8) | p(11), r(3, 11),
                     p(3) | p(5) | p(7) | p(9), p(4) | p(6) | p(8) | p(10), r(3, 10),
                     8'd8, 8'd0, 8'd3, 8'd5, 8'd4, 8'd4);
        vecs[2] = mk("pair", 1'b1, r(2, 3),
                     r(3, 4), r(5, 6), r(3, 6),
                     p(3), p(5), r(3, 5),
                     p(3), p(4), r(3, 4),
                     8'd2, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1);
        vecs[3] = mk("en_off", 1'b0, r(2, 4),
                     '0, '0, '0, '0, '0, '0, '0, '0, '0,
                     8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        vecs[4] = mk("alt", 1'b1, p(2) | p(4) | p(6),
                     p(3) | p(5) | p(7), p(5) | p(7) | p(9), r(3, 9),
                     p(3) | p(7), p(5) | p(9), r(3, 5) | r(7, 9),
                     p(3) | p(5) | p(7), p(4) | p(6) | p(8), r(3, 8),
                     8'd3, 8'd0, 8'd2, 8'd1, 8'd3, 8'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset mid-flight: request at edge 2, rst_n pulsed low between edges 3 and 4.
        do_reset();
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        status = 1'b1;
        @(posedge clk);
        @(negedge clk);
        status = 1'b0;
        chk_outs("midrst pre", 3'b111, 3'b000, 3'b111);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_outs("midrst async", 3'b000, 3'b000, 3'b000);
        chk_cnts("midrst async", '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 4; k <= 8; k++) begin
            chk_outs($sformatf("midrst e%0d", k), 3'b000, 3'b000, 3'b000);
            @(posedge clk);
            @(negedge clk);
        end
        chk_cnts("midrst end", '0, '0);

        // Counter wrap: status held for 400 edges.
        do_reset();
        en     = 1'b1;
        status = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        status = 1'b0;
        chk_cnts("wrap", {8'd200, 8'd134, 8'd144}, {8'd200, 8'd10, 8'd0});
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_outs("wrap drain", 3'b000, 3'b000, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/ab_seq_driver.md
Name: ab_seq_driver

Overview:
- Stimulus-side generator for the "status |=> (a ##GAP b)" handshake.
- Each accepted `status` sample produces a one-cycle `a` pulse on the next clock, then a one-cycle `b` pulse GAP clocks after `a`.
- Drives the a/b lines that the implication assertions in our SVA benches check.
- Configurable to pipeline overlapping requests or to serialise them and drop collisions.

Parameters:
- GAP, 2: clocks from `a` to `b`. Legal range 1..15; elaboration error outside this range.
- ALLOW_OVERLAP, 1: 1 = every accepted request runs independently (pipelined); 0 = one transaction at a time, collisions dropped.
- CNT_W, 8: width of the issue and drop counters.

Ports:
- clk  in  1  sampling clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  request enable; status ignored (not counted) when 0
- status  in  1  request, sampled at posedge
- a  out  1  first-phase pulse
- b  out  1  second-phase pulse
- busy  out  1  a transaction is in flight
- done  out  1  high in every cycle in which b is high
- issue_cnt  out  CNT_W  accepted requests, wraps modulo 2^CNT_W
- drop_cnt  out  CNT_W  rejected requests (ALLOW_OVERLAP=0 only), wraps modulo 2^CNT_W

Behaviour:
- Reset:
  - rst_n low clears a, b, busy, done, issue_cnt, drop_cnt, all pipeline and FSM state, asynchronously.
  - In-flight transactions are discarded; no late a or b after reset release.
- Acceptance: a request is status=1 and en=1 at posedge k. Registered outputs, so:
  - a samples 1 at posedge k+1.
  - b samples 1 at posedge k+1+GAP.
  - done mirrors b exactly.
- ALLOW_OVERLAP=1:
  - a is a 1-flop delay of the accept signal; b is a further GAP-flop shift of a.
  - Every accept increments issue_cnt. Requests on consecutive edges produce overlapping pulse trains.
  - Continuous status gives a=1 and b=1 held steady after the fill latency.
  - busy = OR of all pipeline stages; drop_cnt stays 0.
- ALLOW_OVERLAP=0, FSM states:
  - IDLE: accept -> A_PH; issue_cnt++.
  - A_PH: a=1; next state is GAP_PH (gap counter loaded with GAP-2) if GAP>1, else B_PH.
  - GAP_PH: count down; at 0 go to B_PH.
  - B_PH: b=1, done=1. On accept -> A_PH (back-to-back, issue_cnt++), else -> IDLE.
- Drops (ALLOW_OVERLAP=0):
  - A request sampled in A_PH or GAP_PH is dropped: drop_cnt++, no state change.
  - busy=1 in A_PH, GAP_PH and B_PH.
- en=0: no accept and no drop count. In-flight transactions still complete.
- Counters wrap silently (all ones -> 0).
- a and b never glitch; both are direct flop outputs.

Optional Feature:
- Macro: AB_SEQ_SELFCHECK_EN.
- When defined, adds an embedded concurrent assertion, disabled while rst_n=0: @(posedge clk) (en && status && accepted) |=> (a ##GAP b).
- On failure: $error with $time. An internal fail counter is reported by a final-block $display.
- When not defined: no assertion, no counter; ports and timing identical.

Test Plan:
- GAP=2, OVERLAP=1, reset then single status pulse at edge 2 -> a=1 at edge 3 only; b=1 and done=1 at edge 5 only; issue_cnt=1.
- GAP=2, OVERLAP=1, status held high edges 2-9 -> a=1 at edges 3-10, b=1 at edges 5-12; issue_cnt=8; drop_cnt=0.
- GAP=2, OVERLAP=0, status high edges 2-9:
  - accepts at edges 2, 5 and 8 (B_PH back-to-back); a at 3/6/9; b at 5/8/11.
  - issue_cnt=3; drop_cnt=5.
- GAP=1, OVERLAP=0, pulses at edges 2 and 3 -> a at 3, b at 4 (B_PH); edge-3 request dropped; drop_cnt=1; busy low from edge 5.
- Reset mid-flight: pulse at edge 2, rst_n low between edges 3 and 4 -> all outputs 0 immediately; no b at edge 5; counters 0.
- en=0 with status pulses at edges 2-4 -> no a/b, issue_cnt=0, drop_cnt=0. With AB_SEQ_SELFCHECK_EN and all scenarios above: zero assertion failures.
